cnt_seq_ctrl: RTL
=================

# cnt_seq_ctrl

Bus-master sequencer that runs one timed counting measurement on the counter register block. On a `go` pulse it issues register writes to clear and start the counter, then polls the count register until the count reaches a programmed target, the counter overflows, or a timeout expires. It then stops the counter and reports the result. It sits between system control logic and the counter block's register bus (`wr_en`/`rd_en`/`addr`/`wdata`/`rdata`), acting as that bus's sole master.

## Interface
- `POLL_GAP`, default 4: idle cycles between successive count reads. Legal range is 1..15.
- `TIMEOUT_W`, default 16: width of the timeout cycle counter.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `go` input 1: start request. Sampled only in IDLE.
- `target` input 8: count threshold. Captured on an accepted `go`.
- `busy` output 1: high from the cycle after an accepted `go` through the STOP cycle.
- `done` output 1: one-cycle pulse when a measurement ends.
- `result` output 8: last count read. Held until the next accepted `go`.
- `status` output 2: 00 = target reached, 01 = overflow, 10 = timeout. Held like `result`.
- `wr_en` output 1: register write strobe.
- `rd_en` output 1: register read strobe.
- `addr` output 10: register address.
- `wdata` output 32: write data.
- `rdata` input 32: read data. Valid the cycle after `rd_en`.
- `overflow_in` input 1: counter overflow flag.

## Operation
- Register map:
  - CTRL is at 0x000: bit0 = start, bit1 = clear.
  - CNT is at 0x004: read-only, count in bits [7:0].
- FSM states: IDLE, CLR, START, WAIT, RD, CAP, STOP, DONE.
- IDLE → CLR on `go`. `target` is latched, the timeout counter is zeroed, and the sticky overflow flag is cleared.
- CLR: `wr_en`=1, `addr`=0x000, `wdata`=0x2. Next state is START.
- START: `wr_en`=1, `addr`=0x000, `wdata`=0x1. Next state is WAIT.
- WAIT: gap counter runs POLL_GAP cycles, then moves to RD.
- RD: `rd_en`=1, `addr`=0x004. Next state is CAP.
- CAP: capture `rdata[7:0]` into `result`, then decide, in this priority:
  - sticky overflow set → STOP, `status`=01;
  - captured count ≥ latched target → STOP, `status`=00;
  - timeout counter saturated → STOP, `status`=10;
  - otherwise → WAIT.
- STOP: `wr_en`=1, `addr`=0x000, `wdata`=0x0. Next state is DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Sticky overflow: set by `overflow_in`=1 in any cycle from START through CAP. Cleared only on an accepted `go`.
- Timeout counter: increments every cycle from START through CAP and saturates at all-ones.
- Bus strobes are never both high. `wr_en`/`rd_en` are low in IDLE, WAIT, CAP and DONE. `addr`/`wdata` are 0 whenever no strobe is high.
- `go` while not in IDLE is ignored; no queuing.
- `target`=0: completes on the first poll with `status`=00, unless overflow was seen first.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `result`=0, `status`=00, `wr_en`=0, `rd_en`=0, `addr`=0, `wdata`=0. State is IDLE.
- With `go` sampled at edge N, the first-poll path is:
  - CLR write in cycle N+1;
  - START write in cycle N+2;
  - WAIT in cycles N+3 .. N+2+POLL_GAP;
  - RD in N+3+POLL_GAP, CAP in N+4+POLL_GAP;
  - STOP write in N+5+POLL_GAP, `done` in N+6+POLL_GAP.
- Each additional poll adds POLL_GAP+2 cycles.
- `result` and `status` update in the cycle STOP is entered. They are stable when `done` is high.
- Reset asserted mid-operation returns everything to reset values immediately. No STOP write is issued; the counter may be left running.

## Configuration
- `CNT_SEQ_TIMEOUT_EN` defined: the timeout counter is present and `status`=10 is reachable.
- Not defined: no timeout logic; polling continues until target or overflow; `status` is never 10 and `TIMEOUT_W` is unused.

## Test plan
- Bus model counts +1 per cycle after start; `target`=0, POLL_GAP=4; `go` at cycle 0:
  - writes 0x2 then 0x1 to 0x000 in cycles 1–2;
  - read of 0x004 in cycle 7;
  - write 0x0 in cycle 9;
  - `done` in cycle 10 with `status`=00.
- `target`=20, same model: repeated reads every 6 cycles until a read returns ≥20; `result` ≥20, `status`=00, exactly one STOP write.
- `overflow_in` pulsed for one cycle during WAIT, `target`=200: next CAP ends with `status`=01 even though count < target.
- Macro defined, TIMEOUT_W=6, `rdata` fixed at 0, `target`=0xFF: ends with `status`=10 within 64+POLL_GAP+4 cycles of START. Macro undefined: no `done` within 500 cycles.
- `go` pulsed again during WAIT: ignored; `target` is not re-latched and exactly one `done` is produced.
- `rst` asserted during RD: all outputs 0 in that cycle. A subsequent `go` runs a full clean sequence starting with the CLR write.

Source files
------------

// File: rtl/cnt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cnt_seq_ctrl
//
// Bus-master sequencer for one timed counting measurement on the counter
// register block.
//
// On an accepted `go`, it does the following in order:
//   1. Clears the counter.
//   2. Starts the counter.
//   3. Polls the count register every POLL_GAP+2 cycles.
//   4. Stops when the count reaches the latched target, when overflow has
//      been seen, or (optionally) when the timeout counter saturates.
//   5. Stops the counter and pulses `done`.
//
// Optional feature macro: CNT_SEQ_TIMEOUT_EN
//   defined   -> timeout counter present; status 2'b10 is reachable.
//   undefined -> no timeout logic; TIMEOUT_W is unused.
//
// Parameters
//   POLL_GAP    idle cycles between successive count reads (1..15)
//   TIMEOUT_W   width of the timeout cycle counter
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   go           start request, sampled only in IDLE
//   target[7:0]  count threshold, captured on an accepted go
//   busy         high from the cycle after go through the STOP cycle
//   done         one-cycle end-of-measurement pulse
//   result[7:0]  last count read
//   status[1:0]  00 target reached, 01 overflow, 10 timeout
//   wr_en        register write strobe
//   rd_en        register read strobe
//   addr[9:0]    register address
//   wdata[31:0]  register write data
//   rdata[31:0]  register read data, valid the cycle after rd_en
//   overflow_in  counter overflow flag
// -----------------------------------------------------------------------------
module cnt_seq_ctrl #(
  parameter int POLL_GAP  = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [7:0]  target,
  output logic        busy,
  output logic        done,
  output logic [7:0]  result,
  output logic [1:0]  status,
  output logic        wr_en,
  output logic        rd_en,
  output logic [9:0]  addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        overflow_in
);

  localparam logic [9:0]  ADDR_CTRL  = 10'h000;
  localparam logic [9:0]  ADDR_CNT   = 10'h004;
  localparam logic [31:0] CTRL_CLEAR = 32'h2;
  localparam logic [31:0] CTRL_START = 32'h1;
  localparam logic [31:0] CTRL_STOP  = 32'h0;

  localparam logic [1:0] ST_TARGET  = 2'b00;
  localparam logic [1:0] ST_OVF     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  // The gap counter is loaded with POLL_GAP-1 and counts down to zero, so
  // WAIT lasts exactly POLL_GAP cycles.
  localparam logic [3:0] GAP_LOAD = 4'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_START,
    S_WAIT,
    S_RD,
    S_CAP,
    S_STOP,
    S_DONE
  } state_t;

  state_t      state_reg,  state_next;
  logic [3:0]  gap_reg,    gap_next;
  logic [7:0]  target_reg, target_next;
  logic        ovf_reg,    ovf_next;
  logic [7:0]  result_reg, result_next;
  logic [1:0]  status_reg, status_next;

  // Output registers are driven from the decoded next state.
  // This way each strobe appears in the same cycle as the state it belongs to.
  logic        busy_reg,  busy_next;
  logic        done_reg,  done_next;
  logic        wr_en_reg, wr_en_next;
  logic        rd_en_reg, rd_en_next;
  logic [9:0]  addr_reg,  addr_next;
  logic [31:0] wdata_reg, wdata_next;

`ifdef CNT_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_reg, tmo_next;
`endif

  // True for every cycle from START through CAP.
  // Overflow tracking and the timeout counter are both active in this window.
  logic measuring;
  assign measuring = (state_reg == S_START) || (state_reg == S_WAIT) ||
                     (state_reg == S_RD)    || (state_reg == S_CAP);

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    gap_next    = gap_reg;
    target_next = target_reg;
    ovf_next    = ovf_reg;
    result_next = result_reg;
    status_next = status_reg;
`ifdef CNT_SEQ_TIMEOUT_EN
    tmo_next    = tmo_reg;
    if (measuring && (tmo_reg != {TIMEOUT_W{1'b1}})) begin
      tmo_next = tmo_reg + 1'b1;
    end
`endif

    if (measuring && overflow_in) begin
      ovf_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (go) begin
          state_next  = S_CLR;
          target_next = target;
          ovf_next    = 1'b0;
`ifdef CNT_SEQ_TIMEOUT_EN
          tmo_next    = '0;
`endif
        end
      end

      S_CLR: begin
        state_next = S_START;
      end

      S_START: begin
        state_next = S_WAIT;
        gap_next   = GAP_LOAD;
      end

      S_WAIT: begin
        if (gap_reg == 4'd0) begin
          state_next = S_RD;
        end else begin
          gap_next = gap_reg - 4'd1;
        end
      end

      S_RD: begin
        state_next = S_CAP;
      end

      S_CAP: begin
        // rdata carries the count read in RD during this cycle.
        // An overflow flagged in this very cycle still counts.
        result_next = rdata[7:0];
        if (ovf_reg || overflow_in) begin
          state_next  = S_STOP;
          status_next = ST_OVF;
        end else if (rdata[7:0] >= target_reg) begin
          state_next  = S_STOP;
          status_next = ST_TARGET;
`ifdef CNT_SEQ_TIMEOUT_EN
        end else if (tmo_reg == {TIMEOUT_W{1'b1}}) begin
          state_next  = S_STOP;
          status_next = ST_TIMEOUT;
`endif
        end else begin
          state_next = S_WAIT;
          gap_next   = GAP_LOAD;
        end
      end

      S_STOP: begin
        state_next = S_DONE;
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state.
  // Strobes are mutually exclusive.
  // addr/wdata stay at zero unless a strobe is high.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_next  = 1'b0;
    done_next  = 1'b0;
    wr_en_next = 1'b0;
    rd_en_next = 1'b0;
    addr_next  = '0;
    wdata_next = '0;

    case (state_next)
      S_CLR: begin
        busy_next  = 1'b1;
        wr_en_next = 1'b1;
        addr_next  = ADDR_CTRL;
        wdata_next = CTRL_CLEAR;
      end
      S_START: begin
        busy_next  = 1'b1;
        wr_en_next = 1'b1;
        addr_next  = ADDR_CTRL;
        wdata_next = CTRL_START;
      end
      S_WAIT, S_CAP: begin
        busy_next = 1'b1;
      end
      S_RD: begin
        busy_next  = 1'b1;
        rd_en_next = 1'b1;
        addr_next  = ADDR_CNT;
      end
      S_STOP: begin
        busy_next  = 1'b1;
        wr_en_next = 1'b1;
        addr_next  = ADDR_CTRL;
        wdata_next = CTRL_STOP;
      end
      S_DONE: begin
        done_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      gap_reg    <= '0;
      target_reg <= '0;
      ovf_reg    <= 1'b0;
      result_reg <= '0;
      status_reg <= ST_TARGET;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      wr_en_reg  <= 1'b0;
      rd_en_reg  <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      gap_reg    <= gap_next;
      target_reg <= target_next;
      ovf_reg    <= ovf_next;
      result_reg <= result_next;
      status_reg <= status_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      wr_en_reg  <= wr_en_next;
      rd_en_reg  <= rd_en_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
    end
  end

`ifdef CNT_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_reg <= '0;
    end else begin
      tmo_reg <= tmo_next;
    end
  end
`endif

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign status = status_reg;
  assign wr_en  = wr_en_reg;
  assign rd_en  = rd_en_reg;
  assign addr   = addr_reg;
  assign wdata  = wdata_reg;

endmodule
